// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index 0..WIDTH-1 but never collapse to zero bits.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder. The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
);
    // Handshake: start is a request that is accepted on any rising edge where the adder
    // is in IDLE or DONE; a, b and cin are captured only on that accepting edge. busy is
    // high for the whole RUN phase (start ignored), done is a one-cycle pulse when sum/cout
    // (and ovf) take their new value, and those results hold until the next completion.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif
    state_t           state;

`ifdef SERIAL_ADDER_OVF_EN
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf, state);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf, state);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, state);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, state);
`endif

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// Combinational full adder built from two half-adder stages and an OR of their carries.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic h1_s;
    logic h1_c;
    logic h2_c;

    assign h1_s = x ^ y;
    assign h1_c = x & y;
    assign s    = h1_s ^ ci;
    assign h2_c = h1_s & ci;
    assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder_cell reused over WIDTH cycles, LSB first, carry held in a flop.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] s_msb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;
    logic             last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder_cell u_fa (
        .x  (opa[0]),
        .y  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 holds the first sum bit.
    always_comb begin
        s_msb            = '0;
        s_msb[WIDTH-1]   = fa_s;
        res_next         = (res >> 1) | s_msb;
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        res    <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    carry <= fa_co;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= res_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum_q  <= res_next;
                        cout_q <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the MSB step the carry flop holds the carry into the MSB.
                        ovf_q  <= carry ^ fa_co;
`endif
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.state = state;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit vector table, random ops, multi-cycle corner
// sequences through a result scoreboard, plus an exhaustive sweep of a 1-bit instance.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check helper ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    logic       exp_ovf_q[$];

    logic [W:0] prev_res;
    logic       prev_busy;
    logic       prev_done;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                logic [W:0] e;
                logic       eo;
                e  = exp_q.pop_front();
                eo = exp_ovf_q.pop_front();
                check("result_cout_sum", {bus.cout, bus.sum}, e);
`ifdef SERIAL_ADDER_OVF_EN
                check("result_ovf", bus.ovf, eo);
`endif
            end
            if (prev_done === 1'b1)
                check("done_single_cycle", prev_done, 1'b0);
        end
        if (bus.busy === 1'b1 && prev_busy === 1'b1)
            check("result_stable_in_run", {bus.cout, bus.sum}, prev_res);
        prev_res  = {bus.cout, bus.sum};
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
        logic [W:0] r;
        r = model_sum(a, b, cin);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W:0] e, input logic eo);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        exp_q.push_back(e);
        exp_ovf_q.push_back(eo);
    endtask

    task automatic scramble();
        bus.a   = W'($urandom_range(0, 255));
        bus.b   = W'($urandom_range(0, 255));
        bus.cin = 1'($urandom_range(0, 1));
    endtask

    // Returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] e, input logic eo);
        @(posedge clk);
        #1;
        drive_start(a, b, cin, e, eo);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    // Counts negedges after the accepting edge until done; -1 on timeout.
    task automatic wait_done(output int lat, input bit drop_start);
        lat = -1;
        for (int j = 0; j < 4 * W; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = j;
                if (drop_start) bus.start = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat;
        int done_cnt;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;  bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum", bus.sum, 8'h00);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_state", bus.state, IDLE);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", bus.ovf, 1'b0);
`endif
        check("rst1_cout_sum", {bus1.cout, bus1.sum}, 2'b00);
        check("rst1_busy", bus1.busy, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, vecs[i].ovf);
            @(negedge clk);
            check("busy_after_accept", bus.busy, 1'b1);
            check("state_run", bus.state, RUN);
            // One negedge consumed already; latency counts from the accepting edge.
            wait_done(lat, 1'b0);
            check("latency", lat + 1, W);
            check("busy_low_at_done", bus.busy, 1'b0);
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, model_sum(ra, rb, rc), model_ovf(ra, rb, rc));
            wait_done(lat, 1'b0);
            check("rand_latency", lat, W);
        end

        // start and new operands during RUN are ignored
        issue(8'h10, 8'h20, 1'b0, 9'h030, 1'b0);
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.cin = 1'b1;
        wait_done(lat, 1'b1);
        check("ignore_start_latency", lat, W);
        check("ignore_start_busy_at_done", bus.busy, 1'b0);
        @(negedge clk);
        check("no_second_op_busy", bus.busy, 1'b0);
        check("no_second_op_state", bus.state, IDLE);
        check("held_sum", bus.sum, 8'h30);

        // Synchronous reset in the middle of RUN aborts without a done pulse
        issue(8'h5A, 8'h11, 1'b0, model_sum(8'h5A, 8'h11, 1'b0), model_ovf(8'h5A, 8'h11, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovf_q.delete();
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_sum", bus.sum, 8'h00);
        check("abort_cout", bus.cout, 1'b0);
        check("abort_state", bus.state, IDLE);
        done_cnt = 0;
        for (int j = 0; j < 2 * W; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        issue(8'h21, 8'h43, 1'b1, 9'h065, 1'b0);
        wait_done(lat, 1'b0);
        check("after_abort_latency", lat, W);

        // Back-to-back accept while in DONE
        issue(8'h05, 8'h03, 1'b0, 9'h008, 1'b0);
        wait_done(lat, 1'b0);
        check("b2b_first_latency", lat, W);
        drive_start(8'h0F, 8'hF0, 1'b1, 9'h100, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        @(negedge clk);
        check("b2b_reaccept_busy", bus.busy, 1'b1);
        wait_done(lat, 1'b0);
        check("b2b_second_latency", lat + 1, W);

        // Exhaustive sweep of the WIDTH=1 instance
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e1;
            v  = 3'(i);
            e1 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            @(posedge clk);
            #1;
            bus1.start = 1'b1;
            bus1.a     = v[2];
            bus1.b     = v[1];
            bus1.cin   = v[0];
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            lat = -1;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (bus1.done === 1'b1) begin
                    lat = j;
                    break;
                end
            end
            check("w1_latency", lat, 1);
            check("w1_cout_sum", {bus1.cout, bus1.sum}, e1);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
